// File: rtl/viterbi_ber_monitor_if.sv
// Stream bundle between the tx/rx chain and the BER monitor: source bits entering
// the encoder on the reference side, and decoded bits leaving the Viterbi decoder.
interface viterbi_ber_monitor_if;
    logic ref_valid;
    logic ref_bit;
    logic dec_valid;
    logic dec_bit;

    modport master (output ref_valid, ref_bit, dec_valid, dec_bit);
    modport slave  (input  ref_valid, ref_bit, dec_valid, dec_bit);
endinterface

// File: rtl/viterbi_ber_monitor.sv
// Bit-error-rate monitor: buffers source bits in a reference FIFO, compares each
// decoded bit against the oldest reference bit, and keeps total and per-window error counts.
module viterbi_ber_monitor #(
    parameter int DEPTH = 64,
    parameter int CW    = 16,
    parameter int WIN   = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic [7:0]                 skip_i,
    viterbi_ber_monitor_if.slave       stream,
    output logic                       err_o,
    output logic [CW-1:0]              bit_ct_o,
    output logic [CW-1:0]              err_ct_o,
    output logic [CW-1:0]              win_err_o,
    output logic                       win_done_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       ovf_o,
    output logic                       unf_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;

    typedef enum logic [1:0] {SKIP, RUN, FAULT} state_e;

    state_e          state_q,  state_d;
    logic [7:0]      skip_q,   skip_d;
    logic [AW-1:0]   wrPtr_q,  wrPtr_d;
    logic [AW-1:0]   rdPtr_q,  rdPtr_d;
    logic [LW-1:0]   level_q,  level_d;
    logic [DEPTH-1:0] mem_q;
    logic            err_q,    err_d;
    logic            done_q,   done_d;
    logic [CW-1:0]   bitCt_q,  bitCt_d;
    logic [CW-1:0]   errCt_q,  errCt_d;
    logic [CW-1:0]   winErr_q, winErr_d;
    logic [WW-1:0]   winCnt_q, winCnt_d;
    logic [CW-1:0]   winAcc_q, winAcc_d;
    logic            ovf_q,    ovf_d;
    logic            unf_q,    unf_d;
    logic            memWe;
    logic            refBit;
    logic            mis;
    logic [CW-1:0]   misExt;

    function automatic logic [AW-1:0] ptrNext(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign refBit = mem_q[rdPtr_q];
    assign mis    = refBit ^ stream.dec_bit;
    assign misExt = {{(CW-1){1'b0}}, mis};

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        level_d  = level_q;
        err_d    = 1'b0;
        done_d   = 1'b0;
        bitCt_d  = bitCt_q;
        errCt_d  = errCt_q;
        winErr_d = winErr_q;
        winCnt_d = winCnt_q;
        winAcc_d = winAcc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        memWe    = 1'b0;

        if (state_q != FAULT) begin
            // No bypass: a pop on an empty FIFO faults even if a push arrives alongside it.
            if (stream.dec_valid && level_q == '0) begin
                unf_d   = 1'b1;
                state_d = FAULT;
            end else if (stream.ref_valid && !stream.dec_valid && level_q == LW'(DEPTH)) begin
                ovf_d   = 1'b1;
                state_d = FAULT;
            end else begin
                if (stream.ref_valid) begin
                    memWe   = 1'b1;
                    wrPtr_d = ptrNext(wrPtr_q);
                end
                if (stream.dec_valid) begin
                    rdPtr_d = ptrNext(rdPtr_q);
                end
                if (stream.ref_valid && !stream.dec_valid) begin
                    level_d = level_q + LW'(1);
                end else if (!stream.ref_valid && stream.dec_valid) begin
                    level_d = level_q - LW'(1);
                end

                if (stream.dec_valid && state_q == SKIP) begin
                    skip_d = skip_q - 8'd1;
                    if (skip_q == 8'd1) begin
                        state_d = RUN;
                    end
                end else if (stream.dec_valid && state_q == RUN) begin
                    err_d = mis;
                    if (bitCt_q != '1) begin
                        bitCt_d = bitCt_q + CW'(1);
                    end
                    if (mis && errCt_q != '1) begin
                        errCt_d = errCt_q + CW'(1);
                    end
                    if (winCnt_q == WW'(WIN - 1)) begin
                        done_d   = 1'b1;
                        winErr_d = winAcc_q + misExt;
                        winCnt_d = '0;
                        winAcc_d = '0;
                    end else begin
                        winCnt_d = winCnt_q + WW'(1);
                        winAcc_d = winAcc_q + misExt;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            state_q  <= (skip_i == 8'd0) ? RUN : SKIP;
            skip_q   <= skip_i;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            bitCt_q  <= '0;
            errCt_q  <= '0;
            winErr_q <= '0;
            winCnt_q <= '0;
            winAcc_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            level_q  <= level_d;
            err_q    <= err_d;
            done_q   <= done_d;
            bitCt_q  <= bitCt_d;
            errCt_q  <= errCt_d;
            winErr_q <= winErr_d;
            winCnt_q <= winCnt_d;
            winAcc_q <= winAcc_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            if (memWe) begin
                mem_q[wrPtr_q] <= stream.ref_bit;
            end
        end
    end

    assign err_o      = err_q;
    assign bit_ct_o   = bitCt_q;
    assign err_ct_o   = errCt_q;
    assign win_err_o  = winErr_q;
    assign win_done_o = done_q;
    assign level_o    = level_q;
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Self-checking bench for viterbi_ber_monitor: a queue-based reference model is
// compared against the DUT every cycle, with directed scenarios and a random soak.
module tb_viterbi_ber_monitor;
    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int WIN   = 8;
    localparam int CTMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic [7:0] skip;
    logic errO, winDone, ovfO, unfO;
    logic [CW-1:0] bitCt, errCt, winErr;
    logic [$clog2(DEPTH+1)-1:0] levelO;

    viterbi_ber_monitor_if bus();

    viterbi_ber_monitor #(.DEPTH(DEPTH), .CW(CW), .WIN(WIN)) dut (
        .clk(clk), .rst(rst), .clear_i(clear), .skip_i(skip), .stream(bus),
        .err_o(errO), .bit_ct_o(bitCt), .err_ct_o(errCt), .win_err_o(winErr),
        .win_done_o(winDone), .level_o(levelO), .ovf_o(ovfO), .unf_o(unfO)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;
    int errPulses  = 0;
    int winLog[$];
    bit patQ[$];
    bit invQ[$];

    // Reference model: the FIFO is a plain queue, the skip phase a countdown,
    // counters are integers clamped at the counter maximum.
    bit mq[$];
    int mSkipLeft, mBit, mErrCt, mWinErr, mWinCnt, mWinAcc;
    bit mFault, mErr, mDone, mOvf, mUnf;

    always @(posedge clk) begin : modelProc
        bit r;
        bit m;
        if (!rst || clear) begin
            mq.delete();
            mSkipLeft = skip;
            mFault = 0; mErr = 0; mDone = 0; mOvf = 0; mUnf = 0;
            mBit = 0; mErrCt = 0; mWinErr = 0; mWinCnt = 0; mWinAcc = 0;
        end else begin
            mErr = 0;
            mDone = 0;
            if (!mFault) begin
                if (bus.dec_valid && mq.size() == 0) begin
                    mUnf = 1; mFault = 1;
                end else if (bus.ref_valid && !bus.dec_valid && mq.size() == DEPTH) begin
                    mOvf = 1; mFault = 1;
                end else begin
                    if (bus.dec_valid) begin
                        r = mq.pop_front();
                        if (mSkipLeft > 0) begin
                            mSkipLeft--;
                        end else begin
                            m = r ^ bus.dec_bit;
                            mErr = m;
                            mBit = (mBit + 1 > CTMAX) ? CTMAX : mBit + 1;
                            mErrCt = (mErrCt + m > CTMAX) ? CTMAX : mErrCt + m;
                            mWinAcc += m;
                            mWinCnt++;
                            if (mWinCnt == WIN) begin
                                mDone = 1; mWinErr = mWinAcc; mWinCnt = 0; mWinAcc = 0;
                            end
                        end
                    end
                    if (bus.ref_valid) mq.push_back(bus.ref_bit);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        checkOutput("err_o", errO, mErr);
        checkOutput("win_done_o", winDone, mDone);
        checkOutput("bit_ct_o", bitCt, mBit);
        checkOutput("err_ct_o", errCt, mErrCt);
        checkOutput("win_err_o", winErr, mWinErr);
        checkOutput("level_o", levelO, mq.size());
        checkOutput("ovf_o", ovfO, mOvf);
        checkOutput("unf_o", unfO, mUnf);
        if (errO === 1'b1) errPulses++;
        if (winDone === 1'b1) winLog.push_back(int'(winErr));
    end

    task automatic applyStimulus(input logic r, input logic c, input logic [7:0] s,
                                 input logic rv, input logic rb, input logic dv, input logic db);
        @(negedge clk);
        rst = r; clear = c; skip = s;
        bus.ref_valid = rv; bus.ref_bit = rb;
        bus.dec_valid = dv; bus.dec_bit = db;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'd0, 0, 0, 0, 0);
    endtask

    task automatic doReset(input logic [7:0] s);
        applyStimulus(0, 0, s, 0, 0, 0, 0);
        idle(1);
        errPulses = 0;
        winLog.delete();
    endtask

    task automatic loadPattern(input logic [15:0] pat, input logic [15:0] inv, input int n);
        patQ.delete();
        invQ.delete();
        for (int i = 0; i < n; i++) begin
            patQ.push_back(pat[i]);
            invQ.push_back(inv[i]);
        end
    endtask

    // Each source bit reappears on the decoded side 'delay' cycles later.
    task automatic runStream(input int delay);
        int n;
        bit rv, rb, dv, db;
        n = patQ.size();
        for (int c = 0; c < n + delay; c++) begin
            rv = (c < n);
            rb = rv ? patQ[c] : 1'b0;
            dv = (c >= delay);
            db = dv ? (patQ[c-delay] ^ invQ[c-delay]) : 1'b0;
            applyStimulus(1, 0, 8'd0, rv, rb, dv, db);
        end
        idle(2);
    endtask

    initial begin
        rst = 0; clear = 0; skip = 0;
        bus.ref_valid = 0; bus.ref_bit = 0; bus.dec_valid = 0; bus.dec_bit = 0;

        doReset(8'd0);
        checkOutput("reset bit_ct", bitCt, 0);
        checkOutput("reset level", levelO, 0);
        checkOutput("reset ovf", ovfO, 0);

        // Clean stream of 0xA5A5
        loadPattern(16'hA5A5, 16'h0000, 16);
        runStream(3);
        checkOutput("t1 bit_ct", bitCt, 16);
        checkOutput("t1 err_ct", errCt, 0);
        checkOutput("t1 err pulses", errPulses, 0);
        checkOutput("t1 level", levelO, 0);

        // Decoded bits 3 and 4 inverted
        doReset(8'd0);
        loadPattern(16'hA5A5, 16'h0018, 16);
        runStream(3);
        checkOutput("t2 err_ct", errCt, 2);
        checkOutput("t2 err pulses", errPulses, 2);

        // Warm-up skip of 5 bits hides the inverted first 5
        doReset(8'd5);
        loadPattern(16'($urandom), 16'h001F, 10);
        runStream(3);
        checkOutput("t3 bit_ct", bitCt, 5);
        checkOutput("t3 err_ct", errCt, 0);
        checkOutput("t3 err pulses", errPulses, 0);

        // Windows of 8: one error in the first, three in the second
        doReset(8'd0);
        loadPattern(16'($urandom), 16'h4A04, 16);
        runStream(2);
        checkOutput("t4 windows", winLog.size(), 2);
        if (winLog.size() == 2) begin
            checkOutput("t4 win0", winLog[0], 1);
            checkOutput("t4 win1", winLog[1], 3);
        end
        checkOutput("t4 err_ct", errCt, 4);

        // Overflow, frozen counting, clear, then underflow
        doReset(8'd0);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, 8'd0, 1, i[0], 0, 0);
        idle(1);
        checkOutput("t5 ovf", ovfO, 1);
        checkOutput("t5 level", levelO, DEPTH);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'd0, 0, 0, 1, 1);
        idle(1);
        checkOutput("t5 frozen bit_ct", bitCt, 0);
        applyStimulus(1, 1, 8'd0, 1, 1, 1, 0);
        idle(1);
        checkOutput("t5 clear ovf", ovfO, 0);
        checkOutput("t5 clear level", levelO, 0);
        applyStimulus(1, 0, 8'd0, 0, 0, 1, 0);
        idle(1);
        checkOutput("t5 unf", unfO, 1);

        // Full FIFO with simultaneous push and pop, then reset mid-stream
        doReset(8'd0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 8'd0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'd0, 1, 1, 1, 1);
        idle(1);
        checkOutput("t6 ovf", ovfO, 0);
        checkOutput("t6 level", levelO, DEPTH);
        checkOutput("t6 bit_ct", bitCt, 4);
        applyStimulus(0, 0, 8'd0, 1, 1, 1, 1);
        idle(1);
        checkOutput("t6 rst bit_ct", bitCt, 0);
        checkOutput("t6 rst level", levelO, 0);

        // Long run drives the totals into saturation
        doReset(8'd0);
        patQ.delete();
        invQ.delete();
        for (int i = 0; i < 600; i++) begin
            patQ.push_back(1'($urandom));
            invQ.push_back($urandom_range(0, 3) != 0);
        end
        runStream(2);
        checkOutput("sat bit_ct", bitCt, CTMAX);

        // Random soak with occasional clear/reset and fault recovery
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 499) != 0, $urandom_range(0, 79) == 0,
                          8'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
